cmp_seq_unit: RTL and testbench

Parametrised, multi-cycle magnitude comparator for the ALU datapath. It produces less, equal and greater flags for two WIDTH-bit operands in either signed or unsigned mode. Operands are compared CHUNK bits at a time from the MSB chunk down, and the compare terminates early at the first differing chunk. Valid/ready handshakes on input and output let the ALU control FSM stall the compare or be stalled by it.

---
 rtl/cmp_seq_unit.sv | 134 +++++++++++++
 tb/tb_cmp_seq_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_seq_unit.sv
// Multi-cycle signed/unsigned magnitude comparator, CHUNK bits per cycle, MSB first.
// Ports: clock/reset, in_valid/in_ready + a/b/is_signed in, out_valid/out_ready + flags/chunks_used out.
module cmp_seq_unit #(
  parameter  int WIDTH  = 32,
  parameter  int CHUNK  = 8,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW     = $clog2(NCHUNK) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             less,
  output logic             equal,
  output logic             greater,
  output logic [CW-1:0]    chunks_used
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             less_q, less_d;
  logic             equal_q, equal_d;
  logic             greater_q, greater_d;
  logic [CW-1:0]    used_q, used_d;

  logic [WIDTH-1:0] msk;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic             ch_lt;

  // Flipping the sign bit maps two's complement onto offset binary,
  // so a single unsigned chunk walk handles both modes.
  always_comb begin
    msk = '0;
    msk[WIDTH-1] = is_signed;
  end

  always_comb begin
    a_sh = a_q >> (32'(idx_q) * CHUNK);
    b_sh = b_q >> (32'(idx_q) * CHUNK);
    a_ch = a_sh[CHUNK-1:0];
    b_ch = b_sh[CHUNK-1:0];
    ch_lt = a_ch < b_ch;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
      used_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      less_q    <= less_d;
      equal_q   <= equal_d;
      greater_q <= greater_d;
      used_q    <= used_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    less_d    = less_q;
    equal_d   = equal_q;
    greater_d = greater_q;
    used_d    = used_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a ^ msk;
          b_d     = b ^ msk;
          idx_d   = CW'(NCHUNK - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (a_ch != b_ch) begin
          less_d    = ch_lt;
          greater_d = !ch_lt;
          equal_d   = 1'b0;
          used_d    = CW'(NCHUNK) - idx_q;
          state_d   = DONE;
        end else if (idx_q == '0) begin
          less_d    = 1'b0;
          greater_d = 1'b0;
          equal_d   = 1'b1;
          used_d    = CW'(NCHUNK);
          state_d   = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign less        = less_q;
  assign equal       = equal_q;
  assign greater     = greater_q;
  assign chunks_used = used_q;

endmodule

// File: tb/tb_cmp_seq_unit.sv
// Self-checking bench for cmp_seq_unit (WIDTH=32, CHUNK=8).
// Directed steps with a scoreboard queue of expected results.
module tb_cmp_seq_unit;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic        less;
  logic        equal;
  logic        greater;
  logic [2:0]  chunks_used;

  int checks;
  int failures;

  typedef struct {
    logic l;
    logic e;
    logic g;
    int   used;
  } exp_t;

  exp_t sb[$];

  cmp_seq_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .less        (less),
    .equal       (equal),
    .greater     (greater),
    .chunks_used (chunks_used)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic s);
    exp_t r;
    bit   found;
    if (s) r.l = $signed(x) < $signed(y);
    else   r.l = x < y;
    r.e = (x == y);
    r.g = !r.l && !r.e;
    r.used = 4;
    found = 0;
    for (int i = 3; i >= 0; i--) begin
      if (!found && (x[i*8 +: 8] != y[i*8 +: 8])) begin
        r.used = 4 - i;
        found = 1;
      end
    end
    return r;
  endfunction

  task automatic do_cmp(input logic [31:0] x, input logic [31:0] y,
                        input logic s, input int hold, input bit scramble);
    exp_t e;
    int   n;
    @(negedge clock);
    chk("in_ready_idle", in_ready, 1);
    a = x;
    b = y;
    is_signed = s;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    sb.push_back(model(x, y, s));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    if (scramble) begin
      a = ~x;
      b = $urandom;
      is_signed = ~s;
    end
    n = 0;
    while (n < 40) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (out_valid) break;
      chk("in_ready_run", in_ready, 0);
    end
    chk("out_valid_rise", out_valid, 1);
    e = sb.pop_front();
    chk("less", less, e.l);
    chk("equal", equal, e.e);
    chk("greater", greater, e.g);
    chk("chunks_used", chunks_used, e.used);
    chk("latency", n, e.used);
    chk("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_flags", {less, equal, greater}, {e.l, e.e, e.g});
      chk("hold_used", chunks_used, e.used);
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("handoff_valid", out_valid, 0);
    chk("handoff_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] m;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    is_signed = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", {less, equal, greater}, 3'b000);
    chk("rst_used", chunks_used, 0);
    reset = 1'b0;

    do_cmp(32'hFFFFFFFF, 32'h00000001, 1'b1, 0, 0);
    do_cmp(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 0);
    do_cmp(32'h12345678, 32'h12345678, 1'b1, 0, 0);
    do_cmp(32'h12345678, 32'h12345678, 1'b0, 0, 0);
    do_cmp(32'h12345600, 32'h12345601, 1'b0, 0, 0);
    do_cmp(32'h80000000, 32'h7FFFFFFF, 1'b1, 0, 0);
    do_cmp(32'h80000000, 32'h7FFFFFFF, 1'b0, 0, 0);
    do_cmp(32'h12340000, 32'h12FF0000, 1'b0, 5, 0);
    do_cmp(32'h11223344, 32'h11225544, 1'b1, 0, 1);
    do_cmp(32'hAB00FF00, 32'hAB00FF00, 1'b0, 2, 1);

    // Reset in the middle of an equal compare discards the result.
    @(negedge clock);
    a = 32'h12345678;
    b = 32'h12345678;
    is_signed = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("pre_rst_busy", in_ready, 0);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_flags", {less, equal, greater}, 3'b000);
    chk("midrst_used", chunks_used, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_hold_valid", out_valid, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("post_rst_valid", out_valid, 0);
    end

    do_cmp(32'h00000005, 32'h00000003, 1'b1, 0, 0);

    for (int t = 0; t < 8; t++) begin
      ra = $urandom;
      m = 32'hFFFFFFFF << (8 * $urandom_range(0, 4));
      rb = (ra & m) | ($urandom & ~m);
      do_cmp(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
